// File: rtl/bpsk_demod_rx.sv
// BPSK receive path: integrate-and-dump symbol decisions, sync-word hunt and
// payload bit delivery with frame markers.
module bpsk_demod_rx #(
  parameter int unsigned SAMPLE_W    = 8,
  parameter int unsigned SPS         = 4,
  parameter int unsigned SYNC_LEN    = 8,
  parameter logic [31:0] SYNC_WORD   = 32'h0000_00A7,
  parameter int unsigned PAYLOAD_LEN = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic signed [SAMPLE_W-1:0] sample_in,
  input  logic                       sample_valid,
  output logic                       bit_out,
  output logic                       bit_valid,
  output logic                       frame_start,
  output logic                       frame_done,
  output logic                       in_frame
);

  localparam int unsigned CNT_W  = $clog2(SPS);
  localparam int unsigned ACC_W  = SAMPLE_W + CNT_W;
  localparam int unsigned PCNT_W = (PAYLOAD_LEN > 1) ? $clog2(PAYLOAD_LEN) : 1;
  localparam logic [SYNC_LEN-1:0] SYNC_PAT = SYNC_WORD[SYNC_LEN-1:0];

  typedef enum logic {S_HUNT, S_PAYLOAD} state_t;

  logic signed [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0]        r_cnt;
  logic [SYNC_LEN-1:0]     r_hist;
  logic [PCNT_W-1:0]       r_pcnt;
  state_t                  r_state;
  logic                    r_bit_out;
  logic                    r_bit_valid;
  logic                    r_frame_start;
  logic                    r_frame_done;
  logic                    r_in_frame;

  logic signed [ACC_W-1:0] w_sample_ext;
  logic signed [ACC_W-1:0] w_sum;
  logic                    w_dump;
  logic                    w_dec;
  logic [SYNC_LEN-1:0]     w_hist_shift;
  logic                    w_sync_hit;
  logic                    w_last_bit;

  state_t                  w_state_nx;
  logic [SYNC_LEN-1:0]     w_hist_nx;
  logic [PCNT_W-1:0]       w_pcnt_nx;
  logic                    w_bit_out_nx;
  logic                    w_bit_valid_nx;
  logic                    w_frame_start_nx;
  logic                    w_frame_done_nx;
  logic                    w_in_frame_nx;

  // Sign-extended accumulate; SPS samples of full-scale magnitude fit in ACC_W.
  always_comb begin
    w_sample_ext = {{CNT_W{sample_in[SAMPLE_W-1]}}, sample_in};
    w_sum        = r_acc + w_sample_ext;
    w_dump       = sample_valid && (r_cnt == CNT_W'(SPS - 1));
    w_dec        = !w_sum[ACC_W-1] && (w_sum != '0);
    w_hist_shift = {r_hist[SYNC_LEN-2:0], w_dec};
    w_sync_hit   = (w_hist_shift == SYNC_PAT);
    w_last_bit   = (r_pcnt == PCNT_W'(PAYLOAD_LEN - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (sample_valid) begin
      if (w_dump) begin
        r_acc <= '0;
        r_cnt <= '0;
      end else begin
        r_acc <= w_sum;
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= S_HUNT;
      r_hist        <= '0;
      r_pcnt        <= '0;
      r_bit_out     <= 1'b0;
      r_bit_valid   <= 1'b0;
      r_frame_start <= 1'b0;
      r_frame_done  <= 1'b0;
      r_in_frame    <= 1'b0;
    end else begin
      r_state       <= w_state_nx;
      r_hist        <= w_hist_nx;
      r_pcnt        <= w_pcnt_nx;
      r_bit_out     <= w_bit_out_nx;
      r_bit_valid   <= w_bit_valid_nx;
      r_frame_start <= w_frame_start_nx;
      r_frame_done  <= w_frame_done_nx;
      r_in_frame    <= w_in_frame_nx;
    end
  end

  // in_frame defaults to "currently in PAYLOAD", which keeps it high through
  // the frame_done cycle since the state only leaves PAYLOAD on that edge.
  always_comb begin
    w_state_nx       = r_state;
    w_hist_nx        = r_hist;
    w_pcnt_nx        = r_pcnt;
    w_bit_out_nx     = r_bit_out;
    w_bit_valid_nx   = 1'b0;
    w_frame_start_nx = 1'b0;
    w_frame_done_nx  = 1'b0;
    w_in_frame_nx    = (r_state == S_PAYLOAD);
    if (w_dump) begin
      case (r_state)
        S_HUNT: begin
          if (w_sync_hit) begin
            w_frame_start_nx = 1'b1;
            w_in_frame_nx    = 1'b1;
            w_hist_nx        = '0;
            w_pcnt_nx        = '0;
            w_state_nx       = S_PAYLOAD;
          end else begin
            w_hist_nx = w_hist_shift;
          end
        end
        S_PAYLOAD: begin
          w_bit_valid_nx = 1'b1;
          w_bit_out_nx   = w_dec;
          w_hist_nx      = w_hist_shift;
          w_pcnt_nx      = r_pcnt + PCNT_W'(1);
          if (w_last_bit) begin
            w_frame_done_nx = 1'b1;
            w_hist_nx       = '0;
            w_pcnt_nx       = '0;
            w_state_nx      = S_HUNT;
          end
        end
        default: w_state_nx = S_HUNT;
      endcase
    end
  end

  assign bit_out     = r_bit_out;
  assign bit_valid   = r_bit_valid;
  assign frame_start = r_frame_start;
  assign frame_done  = r_frame_done;
  assign in_frame    = r_in_frame;

endmodule

// File: tb/tb_bpsk_demod_rx.sv
// Directed, table-driven bench for bpsk_demod_rx: one record per symbol with the
// outputs expected one cycle after the symbol's last valid sample.
module tb_bpsk_demod_rx;

  logic              clk = 1'b0;
  logic              rst_n;
  logic signed [7:0] sample_in;
  logic              sample_valid;
  logic              bit_out, bit_valid, frame_start, frame_done, in_frame;

  always #5 clk = ~clk;

  bpsk_demod_rx #(
    .SAMPLE_W   (8),
    .SPS        (4),
    .SYNC_LEN   (8),
    .SYNC_WORD  (32'h0000_00A7),
    .PAYLOAD_LEN(16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sample_in   (sample_in),
    .sample_valid(sample_valid),
    .bit_out     (bit_out),
    .bit_valid   (bit_valid),
    .frame_start (frame_start),
    .frame_done  (frame_done),
    .in_frame    (in_frame)
  );

  // exp = {bit_valid, bit_out, frame_start, frame_done, in_frame}
  typedef struct packed {
    logic [31:0] smp;
    logic [4:0]  exp;
  } vec_t;

  vec_t tbl[$];
  logic last_bo = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   fs_count = 0;
  int   fs_base;

  always @(negedge clk) if (frame_start === 1'b1) fs_count++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Symbol kinds: 0 ideal -1 bit, 1 ideal +1 bit, 2 {127,-128,127,-1}=+125,
  // 3 {-128 x4}=-512, 4 {1,-1,2,-2}=0, 5 {127 x4}=+508.
  function automatic logic [31:0] enc(input int kind);
    case (kind)
      0:       return 32'h9C9C9C9C;
      1:       return 32'h64646464;
      2:       return 32'h7F807FFF;
      3:       return 32'h80808080;
      4:       return 32'h01FF02FE;
      default: return 32'h7F7F7F7F;
    endcase
  endfunction

  task automatic add(input int kind, input logic bv, input logic b,
                     input logic fs, input logic fd, input logic inf);
    if (bv) last_bo = b;
    tbl.push_back(vec_t'{enc(kind), {bv, last_bo, fs, fd, inf}});
  endtask

  // Hunt-phase bits, MSB first; optionally the last one completes the sync word.
  task automatic add_hunt(input logic [7:0] w, input int n, input logic sync_last);
    for (int i = n - 1; i >= 0; i--)
      add(w[i] ? 1 : 0, 1'b0, 1'b0, sync_last && (i == 0), 1'b0, sync_last && (i == 0));
  endtask

  task automatic add_payload(input logic [15:0] p, input int k1, input int k0);
    for (int i = 15; i >= 0; i--)
      add(p[i] ? k1 : k0, 1'b1, p[i], 1'b0, i == 0, 1'b1);
  endtask

  task automatic apply_sym(input vec_t v, input int gap);
    for (int j = 0; j < 4; j++) begin
      @(negedge clk);
      sample_in    = v.smp[31-8*j -: 8];
      sample_valid = 1'b1;
      @(posedge clk);
      #1;
      if (j == 0) chk("pulse_low", {29'd0, bit_valid, frame_start, frame_done}, 32'd0);
      if (j == 3) chk("symbol", {27'd0, bit_valid, bit_out, frame_start, frame_done, in_frame},
                      {27'd0, v.exp});
      if (gap > 0) begin
        @(negedge clk);
        sample_valid = 1'b0;
        sample_in    = 8'sh7F;
        repeat (gap - 1) @(negedge clk);
      end
    end
  endtask

  task automatic run_table(input int gap);
    for (int k = 0; k < tbl.size(); k++) apply_sym(tbl[k], gap);
    tbl.delete();
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  task automatic add_ideal_frame();
    add_hunt(8'h00, 8, 1'b0);
    add_hunt(8'hA7, 8, 1'b1);
    add_payload(16'h5A3C, 1, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n        = 1'b0;
    sample_valid = 1'b0;
    sample_in    = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", {27'd0, bit_valid, bit_out, frame_start, frame_done, in_frame}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Ideal frame, continuous samples
    fs_base = fs_count;
    add_ideal_frame();
    run_table(0);
    @(posedge clk); #1;
    chk("in_frame_after_done", {31'd0, in_frame}, 32'd0);
    chk("ideal_fs_count", fs_count - fs_base, 32'd1);

    // Same frame with 3 idle cycles between every sample
    fs_base = fs_count;
    add_ideal_frame();
    run_table(3);
    chk("gapped_fs_count", fs_count - fs_base, 32'd1);

    // Extreme / zero-sum samples forming sync and payload
    fs_base = fs_count;
    add_hunt(8'h00, 4, 1'b0);
    add(2, 0, 0, 0, 0, 0); add(4, 0, 0, 0, 0, 0); add(5, 0, 0, 0, 0, 0); add(3, 0, 0, 0, 0, 0);
    add(4, 0, 0, 0, 0, 0); add(2, 0, 0, 0, 0, 0); add(5, 0, 0, 0, 0, 0); add(2, 0, 0, 1, 0, 1);
    add_payload(16'h5A3C, 2, 4);
    run_table(0);
    chk("extreme_fs_count", fs_count - fs_base, 32'd1);

    // Sync word inside payload, then back-to-back sync after frame_done
    fs_base = fs_count;
    add_hunt(8'hA7, 8, 1'b1);
    add_payload(16'hA7A7, 1, 0);
    add_hunt(8'hA7, 8, 1'b1);
    add_payload(16'h0F0F, 1, 0);
    run_table(0);
    chk("sync_in_payload_fs_count", fs_count - fs_base, 32'd2);

    // Near-miss sync words
    fs_base = fs_count;
    add_hunt(8'hA6, 8, 1'b0);
    add_hunt(8'h27, 8, 1'b0);
    add_hunt(8'hA7, 8, 1'b1);
    add_payload(16'hC3A5, 1, 0);
    run_table(0);
    chk("near_miss_fs_count", fs_count - fs_base, 32'd1);

    // Reset after payload bit 5, then a clean frame
    add_hunt(8'hA7, 8, 1'b1);
    add(0, 1, 0, 0, 0, 1); add(1, 1, 1, 0, 0, 1); add(0, 1, 0, 0, 0, 1);
    add(1, 1, 1, 0, 0, 1); add(1, 1, 1, 0, 0, 1);
    run_table(0);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("async_reset_outputs", {27'd0, bit_valid, bit_out, frame_start, frame_done, in_frame}, 32'd0);
    last_bo = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    fs_base = fs_count;
    add_ideal_frame();
    run_table(0);
    chk("post_reset_fs_count", fs_count - fs_base, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
